// File: rtl/hip_rst_seq.sv
// PCIe HIP application reset sequencer: merges exit pulses, readiness levels and
// LTSSM-disable into one request, holds, then releases staged resets in order.
module hip_rst_seq #(
  parameter int          NUM_EXIT      = 3,
  parameter int          NUM_RDY       = 2,
  parameter int          NUM_STAGE     = 2,
  parameter int          POR_HOLD      = 1024,
  parameter int          EXIT_HOLD     = 16,
  parameter int          SIM_HOLD      = 32,
  parameter int          STAGE_GAP     = 8,
  parameter logic [4:0]  LTSSM_DISABLE = 5'h10,
  parameter int          CNT_W         = 11,
  parameter int          EVT_W         = 8
) (
  input  logic                 iPLD_CLK,
  input  logic                 iNPOR_n,
  input  logic [NUM_EXIT-1:0]  iEXIT_n,
  input  logic [NUM_RDY-1:0]   iREADY,
  input  logic [4:0]           iLTSSMSTATE,
  input  logic                 iSIM_FAST,
  input  logic                 iEVT_CLR,
  output logic [NUM_STAGE-1:0] oAPP_RST_n,
  output logic                 oCRST,
  output logic [1:0]           oSTATE,
  output logic [EVT_W-1:0]     oRST_EVT_CNT
);

  typedef enum logic [1:0] {
    ST_POR   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STAGE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int                REL_W = $clog2(NUM_STAGE + 1);
  localparam logic [CNT_W-1:0]  POR_H  = CNT_W'(POR_HOLD);
  localparam logic [CNT_W-1:0]  EXIT_H = CNT_W'(EXIT_HOLD);
  localparam logic [CNT_W-1:0]  SIM_H  = CNT_W'(SIM_HOLD);
  localparam logic [CNT_W-1:0]  GAP    = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // NOTE: reset asserts asynchronously but releases only after two clean clock
  // edges, so no downstream flop ever sees a deassertion near its clock edge.
  logic [1:0] sync_q;
  logic       npor_sync;

  always_ff @(posedge iPLD_CLK or negedge iNPOR_n) begin
    if (!iNPOR_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end
  assign npor_sync = sync_q[1];

  logic [NUM_EXIT-1:0]  exit_q;
  logic [NUM_RDY-1:0]   rdy_q;
  logic [4:0]           ltssm_q;
  logic                 req_q,   req_d;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [REL_W-1:0]     rel_q,   rel_d;
  logic [EVT_W-1:0]     evt_q,   evt_d;
  logic [NUM_STAGE-1:0] app_q,   app_d;
  logic                 crst_q,  crst_d;
  logic [1:0]           sto_q;
  logic                 evt_inc;
  logic [CNT_W-1:0]     por_h, exit_h;

  assign por_h  = iSIM_FAST ? SIM_H : POR_H;
  assign exit_h = iSIM_FAST ? SIM_H : EXIT_H;
  assign req_d  = ~(&exit_q) | ~(&rdy_q) | (ltssm_q == LTSSM_DISABLE);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    evt_inc = 1'b0;
    unique case (state_q)
      ST_POR, ST_HOLD: begin
        if (req_q) begin
          cnt_d = (state_q == ST_POR) ? por_h : exit_h;
        end else if (cnt_q <= CNT_ONE) begin
          rel_d   = REL_W'(1);
          cnt_d   = GAP;
          state_d = (NUM_STAGE == 1) ? ST_RUN : ST_STAGE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STAGE, ST_RUN: begin
        if (req_q) begin
          state_d = ST_HOLD;
          cnt_d   = exit_h;
          rel_d   = '0;
          evt_inc = 1'b1;
        end else if (state_q == ST_STAGE) begin
          if (cnt_q <= CNT_ONE) begin
            rel_d = rel_q + REL_W'(1);
            cnt_d = GAP;
            if ((rel_q + REL_W'(1)) == REL_W'(NUM_STAGE)) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = ST_POR;
    endcase
  end

  // Clear wins over the old value but still honours a same-cycle event.
  always_comb begin
    evt_d = evt_q;
    if (iEVT_CLR)                   evt_d = evt_inc ? EVT_W'(1) : '0;
    else if (evt_inc && ~&evt_q)    evt_d = evt_q + EVT_W'(1);
  end

  always_comb begin
    app_d = '0;
    for (int k = 0; k < NUM_STAGE; k++) app_d[k] = (rel_q > REL_W'(k));
    crst_d = (rel_q == '0);
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge iPLD_CLK or negedge npor_sync) begin
    if (!npor_sync) begin
      exit_q  <= '1;
      rdy_q   <= '0;
      ltssm_q <= '0;
      req_q   <= 1'b1;
      state_q <= ST_POR;
      cnt_q   <= POR_H;
      rel_q   <= '0;
      evt_q   <= '0;
      app_q   <= '0;
      crst_q  <= 1'b1;
      sto_q   <= 2'd0;
    end else begin
      exit_q  <= iEXIT_n;
      rdy_q   <= iREADY;
      ltssm_q <= iLTSSMSTATE;
      req_q   <= req_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      evt_q   <= evt_d;
      app_q   <= app_d;
      crst_q  <= crst_d;
      sto_q   <= state_q;
    end
  end

  assign oAPP_RST_n   = app_q;
  assign oCRST        = crst_q;
  assign oSTATE       = sto_q;
  assign oRST_EVT_CNT = evt_q;

endmodule
